// File: rtl/fp_align_add.sv
`default_nettype none
// ============================================================================
// Module  : fp_align_add
// Brief   : 3-stage FP16 unpack/align/add pipeline producing an unnormalised
//           sum with sticky and special-case flags for a downstream normaliser.
// Revision: 1.0 - initial release
// ============================================================================
module fp_align_add #(
  parameter int MANTISSA = 11,
  parameter int EXPONENT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         in_a,
  input  logic [15:0]         in_b,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXPONENT-1:0] out_exponent,
  output logic [MANTISSA:0]   out_mantissa,
  output logic                out_sticky,
  output logic                out_zero,
  output logic                out_inf,
  output logic                out_nan
);

  localparam int                  c_frac_w  = MANTISSA - 1;
  localparam int                  c_sum_w   = MANTISSA + 1;
  localparam logic [EXPONENT-1:0] c_exp_max = '1;

  logic w_advance;

  // ---------------------------------------------------------------- S1 logic
  logic                w_sign_a, w_sign_b;
  logic [EXPONENT-1:0] w_exp_a, w_exp_b;
  logic [c_frac_w-1:0] w_frac_a, w_frac_b;
  logic [MANTISSA-1:0] w_mant_a, w_mant_b;
  logic                w_a_big;
  logic [EXPONENT-1:0] w_exp_big, w_exp_small;
  logic                w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic                w_nan_in, w_inf_in, w_inf_sign, w_neg_zero;

  assign w_sign_a = in_a[15];
  assign w_sign_b = in_b[15];
  assign w_exp_a  = in_a[c_frac_w +: EXPONENT];
  assign w_exp_b  = in_b[c_frac_w +: EXPONENT];
  assign w_frac_a = in_a[c_frac_w-1:0];
  assign w_frac_b = in_b[c_frac_w-1:0];

  // Subnormals are flushed: a zero exponent contributes no significand at all.
  assign w_mant_a = (w_exp_a != '0) ? {1'b1, w_frac_a} : '0;
  assign w_mant_b = (w_exp_b != '0) ? {1'b1, w_frac_b} : '0;

  assign w_a_big     = {w_exp_a, w_mant_a} >= {w_exp_b, w_mant_b};
  assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
  assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;

  assign w_nan_a    = (w_exp_a == c_exp_max) && (w_frac_a != '0);
  assign w_nan_b    = (w_exp_b == c_exp_max) && (w_frac_b != '0);
  assign w_inf_a    = (w_exp_a == c_exp_max) && (w_frac_a == '0);
  assign w_inf_b    = (w_exp_b == c_exp_max) && (w_frac_b == '0);
  assign w_nan_in   = w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b));
  assign w_inf_in   = !w_nan_in && (w_inf_a || w_inf_b);
  assign w_inf_sign = w_inf_a ? w_sign_a : w_sign_b;
  assign w_neg_zero = w_sign_a && w_sign_b && (w_mant_a == '0) && (w_mant_b == '0);

  logic                r_s1_valid;
  logic                r_s1_sign;
  logic                r_s1_eff_sub;
  logic [EXPONENT-1:0] r_s1_exp;
  logic [EXPONENT-1:0] r_s1_diff;
  logic [MANTISSA-1:0] r_s1_mant_big;
  logic [MANTISSA-1:0] r_s1_mant_small;
  logic                r_s1_nan, r_s1_inf, r_s1_inf_sign, r_s1_neg_zero;

  // ---------------------------------------------------------------- S2 logic
  logic [MANTISSA-1:0] w_aligned;
  logic [MANTISSA-1:0] w_mask;
  logic                w_sticky;

  always_comb begin
    w_aligned = '0;
    w_mask    = '0;
    w_sticky  = 1'b0;
    if (int'(r_s1_diff) >= MANTISSA + 1) begin
      w_sticky = |r_s1_mant_small;
    end else begin
      w_aligned = r_s1_mant_small >> r_s1_diff;
      w_mask    = ~({MANTISSA{1'b1}} << r_s1_diff);
      w_sticky  = |(r_s1_mant_small & w_mask);
    end
  end

  logic                r_s2_valid;
  logic                r_s2_sign;
  logic                r_s2_eff_sub;
  logic [EXPONENT-1:0] r_s2_exp;
  logic [MANTISSA-1:0] r_s2_mant_big;
  logic [MANTISSA-1:0] r_s2_aligned;
  logic                r_s2_sticky;
  logic                r_s2_nan, r_s2_inf, r_s2_inf_sign, r_s2_neg_zero;

  // ---------------------------------------------------------------- S3 logic
  // Magnitude ordering in S1 guarantees big >= aligned, so subtraction never
  // wraps and the extra top bit only ever holds an addition carry.
  logic [c_sum_w-1:0]  w_sum;
  logic                w_res_sign, w_res_sticky, w_res_zero, w_res_inf, w_res_nan;
  logic [EXPONENT-1:0] w_res_exp;
  logic [c_sum_w-1:0]  w_res_mant;

  assign w_sum = r_s2_eff_sub ? ({1'b0, r_s2_mant_big} - {1'b0, r_s2_aligned})
                              : ({1'b0, r_s2_mant_big} + {1'b0, r_s2_aligned});

  always_comb begin
    w_res_sign   = r_s2_sign;
    w_res_exp    = r_s2_exp;
    w_res_mant   = w_sum;
    w_res_sticky = r_s2_sticky;
    w_res_zero   = 1'b0;
    w_res_inf    = 1'b0;
    w_res_nan    = 1'b0;
    if (r_s2_nan) begin
      w_res_nan    = 1'b1;
      w_res_sign   = 1'b0;
      w_res_exp    = c_exp_max;
      w_res_mant   = '0;
      w_res_sticky = 1'b0;
    end else if (r_s2_inf) begin
      w_res_inf    = 1'b1;
      w_res_sign   = r_s2_inf_sign;
      w_res_exp    = c_exp_max;
      w_res_mant   = '0;
      w_res_sticky = 1'b0;
    end else if (w_sum == '0) begin
      w_res_zero = 1'b1;
      w_res_sign = r_s2_neg_zero;
      w_res_exp  = '0;
      w_res_mant = '0;
    end
  end

  logic                r_out_valid;
  logic                r_out_sign;
  logic [EXPONENT-1:0] r_out_exponent;
  logic [c_sum_w-1:0]  r_out_mantissa;
  logic                r_out_sticky, r_out_zero, r_out_inf, r_out_nan;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign w_advance = out_ready || !r_out_valid;
  assign in_ready  = w_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid      <= 1'b0;
      r_s1_sign       <= 1'b0;
      r_s1_eff_sub    <= 1'b0;
      r_s1_exp        <= '0;
      r_s1_diff       <= '0;
      r_s1_mant_big   <= '0;
      r_s1_mant_small <= '0;
      r_s1_nan        <= 1'b0;
      r_s1_inf        <= 1'b0;
      r_s1_inf_sign   <= 1'b0;
      r_s1_neg_zero   <= 1'b0;
      r_s2_valid      <= 1'b0;
      r_s2_sign       <= 1'b0;
      r_s2_eff_sub    <= 1'b0;
      r_s2_exp        <= '0;
      r_s2_mant_big   <= '0;
      r_s2_aligned    <= '0;
      r_s2_sticky     <= 1'b0;
      r_s2_nan        <= 1'b0;
      r_s2_inf        <= 1'b0;
      r_s2_inf_sign   <= 1'b0;
      r_s2_neg_zero   <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_sign      <= 1'b0;
      r_out_exponent  <= '0;
      r_out_mantissa  <= '0;
      r_out_sticky    <= 1'b0;
      r_out_zero      <= 1'b0;
      r_out_inf       <= 1'b0;
      r_out_nan       <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid      <= in_valid;
      r_s1_sign       <= w_a_big ? w_sign_a : w_sign_b;
      r_s1_eff_sub    <= w_sign_a != w_sign_b;
      r_s1_exp        <= w_exp_big;
      r_s1_diff       <= w_exp_big - w_exp_small;
      r_s1_mant_big   <= w_a_big ? w_mant_a : w_mant_b;
      r_s1_mant_small <= w_a_big ? w_mant_b : w_mant_a;
      r_s1_nan        <= w_nan_in;
      r_s1_inf        <= w_inf_in;
      r_s1_inf_sign   <= w_inf_sign;
      r_s1_neg_zero   <= w_neg_zero;

      r_s2_valid      <= r_s1_valid;
      r_s2_sign       <= r_s1_sign;
      r_s2_eff_sub    <= r_s1_eff_sub;
      r_s2_exp        <= r_s1_exp;
      r_s2_mant_big   <= r_s1_mant_big;
      r_s2_aligned    <= w_aligned;
      r_s2_sticky     <= w_sticky;
      r_s2_nan        <= r_s1_nan;
      r_s2_inf        <= r_s1_inf;
      r_s2_inf_sign   <= r_s1_inf_sign;
      r_s2_neg_zero   <= r_s1_neg_zero;

      r_out_valid     <= r_s2_valid;
      r_out_sign      <= w_res_sign;
      r_out_exponent  <= w_res_exp;
      r_out_mantissa  <= w_res_mant;
      r_out_sticky    <= w_res_sticky;
      r_out_zero      <= w_res_zero;
      r_out_inf       <= w_res_inf;
      r_out_nan       <= w_res_nan;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sign     = r_out_sign;
  assign out_exponent = r_out_exponent;
  assign out_mantissa = r_out_mantissa;
  assign out_sticky   = r_out_sticky;
  assign out_zero     = r_out_zero;
  assign out_inf      = r_out_inf;
  assign out_nan      = r_out_nan;

endmodule
`default_nettype wire
